// File: rtl/debug_uart_tx_if.sv
// Signal bundle between the CPU debug ports and the debug UART transmitter.
// start is a request with no separate ready: it is taken on any rising edge where busy is low and dropped otherwise.
interface debug_uart_tx_if;
  logic       start;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       done;
  logic [1:0] fsmState;

  modport master (
    output start, debug_port1, debug_port2, debug_port3, debug_port4,
           debug_port5, debug_port6, debug_port7,
    input  tx, busy, done, fsmState
  );

  modport slave (
    input  start, debug_port1, debug_port2, debug_port3, debug_port4,
           debug_port5, debug_port6, debug_port7,
    output tx, busy, done, fsmState
  );
endinterface

// File: rtl/debug_uart_tx.sv
// Debug packet transmitter: captures seven CPU debug bytes and sends
// SYNC, p1..p7, XOR checksum as 8N1 UART frames with no gap between bytes.
module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input logic           clk,
  input logic           nreset,
  debug_uart_tx_if.slave bus
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} stateT;

  stateT         state, stateNext;
  logic [BW-1:0] baudCnt, baudNext;
  logic [2:0]    bitIdx, bitNext;
  logic [3:0]    byteIdx, byteNext;
  logic [7:0]    captureBuf [7];
  logic [7:0]    chk;
  logic [7:0]    nextByte;
  logic          capture;
  logic          doneNext;
  logic          txNext;
  logic          baudEnd;
  logic          txReg, busyReg, doneReg;

  assign baudEnd = (baudCnt == BAUD_LAST);

  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    byteNext  = byteIdx;
    capture   = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          stateNext = START_BIT;
          baudNext  = '0;
          bitNext   = '0;
          byteNext  = '0;
        end
      end
      START_BIT: begin
        if (baudEnd) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA_BITS;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      DATA_BITS: begin
        if (baudEnd) begin
          baudNext = '0;
          if (bitIdx == 3'd7) stateNext = STOP_BIT;
          else                bitNext   = bitIdx + 3'd1;
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baudEnd) begin
          baudNext = '0;
          if (byteIdx == 4'd8) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            byteNext  = byteIdx + 4'd1;
            stateNext = START_BIT;
          end
        end else begin
          baudNext = baudCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The buffer is stable while busy, so the next byte can be picked from it directly.
  always_comb begin
    nextByte = SYNC_BYTE;
    if (byteNext == 4'd8)      nextByte = chk;
    else if (byteNext != 4'd0) nextByte = captureBuf[3'(byteNext - 4'd1)];
  end

  always_comb begin
    txNext = 1'b1;
    case (stateNext)
      START_BIT: txNext = 1'b0;
      DATA_BITS: txNext = nextByte[bitNext];
      default:   txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      byteIdx <= '0;
      chk     <= '0;
      for (int i = 0; i < 7; i++) captureBuf[i] <= '0;
      txReg   <= 1'b1;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      baudCnt <= baudNext;
      bitIdx  <= bitNext;
      byteIdx <= byteNext;
      if (capture) begin
        captureBuf[0] <= bus.debug_port1;
        captureBuf[1] <= bus.debug_port2;
        captureBuf[2] <= bus.debug_port3;
        captureBuf[3] <= bus.debug_port4;
        captureBuf[4] <= bus.debug_port5;
        captureBuf[5] <= bus.debug_port6;
        captureBuf[6] <= bus.debug_port7;
        chk <= bus.debug_port1 ^ bus.debug_port2 ^ bus.debug_port3 ^
               bus.debug_port4 ^ bus.debug_port5 ^ bus.debug_port6 ^
               bus.debug_port7;
      end
      txReg   <= txNext;
      busyReg <= (stateNext != IDLE);
      doneReg <= doneNext;
    end
  end

  assign bus.tx       = txReg;
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.fsmState = state;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx: decodes the serial line mid-bit and checks
// packet contents, latency, span, done/busy timing, busy rejection and async reset.
module tb_debug_uart_tx;
  localparam int CPB = 4;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   cyc    = 0;
  int   nCmp   = 0;
  int   nFail  = 0;
  int   c0     = 0;
  logic [7:0] expPkt [9];

  debug_uart_tx_if bus();

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setPorts(input logic [7:0] p1, p2, p3, p4, p5, p6, p7);
    bus.debug_port1 = p1; bus.debug_port2 = p2; bus.debug_port3 = p3;
    bus.debug_port4 = p4; bus.debug_port5 = p5; bus.debug_port6 = p6;
    bus.debug_port7 = p7;
  endtask

  task automatic setExp(input logic [7:0] p1, p2, p3, p4, p5, p6, p7, c);
    expPkt[0] = 8'hA5; expPkt[1] = p1; expPkt[2] = p2; expPkt[3] = p3;
    expPkt[4] = p4;    expPkt[5] = p5; expPkt[6] = p6; expPkt[7] = p7;
    expPkt[8] = c;
  endtask

  // Called at a negedge; returns at the negedge of the last stop-bit cycle.
  task automatic recvByte(output logic [7:0] b, input string tag);
    int n = 0;
    while (bus.tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(32'(bus.tx), 32'd0, {tag, " start"});
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = bus.tx;
    end
    repeat (CPB) @(negedge clk);
    check(32'(bus.tx), 32'd1, {tag, " stop"});
    repeat (CPB - 2) @(negedge clk);
  endtask

  task automatic recvPacket(input string tag);
    logic [7:0] b;
    for (int k = 0; k < 9; k++) begin
      recvByte(b, $sformatf("%s byte%0d", tag, k));
      check(32'(b), 32'(expPkt[k]), $sformatf("%s byte%0d", tag, k));
    end
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int extraDone;
    int lowSeen;
    bus.start = 1'b0;
    setPorts(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      check(32'({bus.tx, bus.busy, bus.done}), 32'b100, "reset hold");
    end
    nreset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check(32'({bus.tx, bus.busy, bus.done}), 32'b100, "reset idle");
    end
    check(32'(bus.fsmState), 32'd0, "idle state");

    // Single packet
    setPorts(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
    setExp(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F);
    @(negedge clk);
    pulseStart();
    check(32'({bus.busy, bus.tx}), 32'b10, "single latency");
    c0 = cyc;
    recvPacket("single");
    @(negedge clk);
    check(32'({bus.done, bus.busy}), 32'b10, "single done");
    check(32'(cyc - c0), 32'd360, "single span");
    @(negedge clk);
    check(32'(bus.done), 32'd0, "single done width");

    // Busy rejection: start held and ports changed mid-packet
    setPorts(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE);
    setExp(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    pulseStart();
    for (int k = 0; k < 9; k++) begin
      if (k == 3) begin
        bus.start = 1'b1;
        setPorts(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      end
      recvByte(b, $sformatf("reject byte%0d", k));
      check(32'(b), 32'(expPkt[k]), $sformatf("reject byte%0d", k));
      if (k == 3) bus.start = 1'b0;
    end
    @(negedge clk);
    check(32'({bus.done, bus.busy}), 32'b10, "reject done");
    extraDone = 0;
    lowSeen   = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done)   extraDone++;
      if (!bus.tx)    lowSeen++;
    end
    check(32'(extraDone), 32'd0, "reject extra done");
    check(32'(lowSeen), 32'd0, "reject no second packet");

    // Back-to-back with start held high
    setPorts(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    setExp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.start = 1'b1;
    @(negedge clk);
    setPorts(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11);
    check(32'(bus.busy), 32'd1, "b2b latency");
    recvPacket("b2b pkt1");
    @(negedge clk);
    check(32'({bus.done, bus.tx, bus.busy}), 32'b110, "b2b gap");
    @(negedge clk);
    check(32'({bus.tx, bus.busy}), 32'b01, "b2b restart");
    bus.start = 1'b0;
    setExp(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11);
    recvPacket("b2b pkt2");
    @(negedge clk);
    check(32'(bus.done), 32'd1, "b2b done2");
    @(negedge clk);
    check(32'({bus.done, bus.busy, bus.tx}), 32'b001, "b2b end idle");

    // Bit order and checksum
    setPorts(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    setExp(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h81);
    pulseStart();
    recvPacket("bitorder");
    @(negedge clk);
    check(32'(bus.done), 32'd1, "bitorder done");

    // Async reset during a data bit of byte 3
    setPorts(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE);
    setExp(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    @(negedge clk);
    pulseStart();
    for (int k = 0; k < 3; k++) begin
      recvByte(b, $sformatf("areset byte%0d", k));
      check(32'(b), 32'(expPkt[k]), $sformatf("areset byte%0d", k));
    end
    repeat (10) @(negedge clk);
    check(32'(bus.fsmState), 32'd2, "areset in data bits");
    #2 nreset = 1'b0;
    #1;
    check(32'({bus.tx, bus.busy, bus.done}), 32'b100, "areset immediate");
    check(32'(bus.fsmState), 32'd0, "areset state");
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    lowSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.tx || bus.busy) lowSeen++;
    end
    check(32'(lowSeen), 32'd0, "areset no resume");
    pulseStart();
    recvPacket("post reset");
    @(negedge clk);
    check(32'(bus.done), 32'd1, "post reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Serial transmitter for the CPU debug interface. It is the sending end of the link to the host-side serial port debugger.
- On a start pulse it captures the seven 8-bit debug ports from cpu.
- It sends the captured bytes as one framed packet over a standard 8N1 UART line: sync byte, seven payload bytes, XOR checksum.
- It sits between cpu and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal values are 2 and above.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  request to capture and send one packet; sampled on the rising edge of clk.
- debug_port1 .. debug_port7  input  8 each  debug bytes from cpu.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a packet is captured or being sent.
- done  output  1  one-cycle pulse when the last stop bit of a packet completes.

Behaviour:
- Reset (nreset=0, asynchronous): tx=1, busy=0, done=0. State returns to IDLE. Bit counter, byte index, baud counter and capture registers are cleared.
- Reset released mid-packet: the line stays idle high. No partial byte resumes.
- State machine: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT -> (next byte: START_BIT | packet end: IDLE).
- IDLE:
  - tx=1, busy=0.
  - start=1 at an edge captures debug_port1..7 into a 7-byte buffer.
  - On that edge it also computes chk = p1^p2^...^p7 and sets byte index=0.
  - Next state is START_BIT. busy=1 and tx=0 appear on the cycle after the capture edge (latency 1).
- Byte sequence, index 0..8: SYNC_BYTE, p1, p2, p3, p4, p5, p6, p7, chk. Nine bytes per packet.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. At its end:
  - if index<8: increment index and go to START_BIT. No idle gap between bytes.
  - if index==8: go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Every bit boundary is exactly CLKS_PER_BIT cycles.
- Packet timing:
  - 90*CLKS_PER_BIT cycles from the first tx falling edge to the end of the last stop bit.
  - On the cycle after the last stop bit ends: done=1 for exactly one cycle, busy=0, state=IDLE.
- start while busy=1 is ignored. It is not queued, and the capture buffer is unchanged.
- start in the same cycle as done (busy=0): accepted as a normal IDLE start.
- Back-to-back packets therefore have one idle-high cycle minimum between the last stop bit and the next start bit.
- debug_port changes after capture have no effect on the packet in flight.
- start held high continuously sends packets repeatedly, each one separated by the minimum one-cycle gap.
- All outputs are registered; tx has no combinational path from any input.

Test Plan (CLKS_PER_BIT=4, SYNC_BYTE=8'hA5):
- Reset idle: hold nreset=0 for 3 cycles, then release with start=0 for 20 cycles -> tx=1, busy=0, done=0 throughout.
- Single packet:
  - Stimulus: ports = 01,02,04,08,10,20,40; pulse start.
  - busy rises 1 cycle later.
  - The decoded bytes are A5,01,02,04,08,10,20,40,7F.
  - Each bit is 4 cycles; the total span is 360 cycles.
  - done pulses once; busy falls in the same cycle.
- Busy rejection:
  - Stimulus: mid-packet, pulse start again and change all ports to FF.
  - The packet in flight completes with its original bytes.
  - No second packet follows; exactly one done pulse.
- Back-to-back:
  - Stimulus: hold start=1. First ports = all 00; after the first capture, ports = all 11.
  - Packet 1 = A5, 00 x7, 00.
  - Exactly 1 idle-high cycle follows.
  - Packet 2 = A5, 11 x7, 11.
- Async reset mid-frame:
  - Stimulus: assert nreset=0 between clock edges during a data bit of byte 3.
  - tx goes to 1 and busy goes to 0 immediately, without waiting for an edge.
  - After release plus a start pulse, a fresh packet begins from SYNC_BYTE.
- Bit order/checksum: ports = 80,00,00,00,00,00,01 -> byte p1 is sent as bits 0000_0001 in time order (LSB first), and chk=81.
